booth2_signed_divider: RTL and testbench
========================================

// Module: booth2_signed_divider
// PURPOSE
//  Sequential signed divider; the inverse of the Booth-2 signed multiplier.
//  Divides a 2N-bit signed dividend (e.g. a multiplier final_result) by an
//  N-bit signed divisor, giving a 2N-bit quotient and an N-bit remainder.
//  Restoring division on magnitudes, one quotient bit per clock, then sign fix.
//  Sits beside the multiplier so results can be round-tripped and checked.
// PARAMETERS
//  N  4  divisor/remainder width; dividend and quotient are 2N bits
// PORTS
//  CLK           in   1   clock, rising edge
//  RST           in   1   asynchronous, active-low reset
//  start         in   1   request; accepted only when busy=0
//  dividend      in   2N  signed dividend, sampled on the accepting edge
//  divisor       in   N   signed divisor, sampled on the accepting edge
//  busy          out  1   high from the accepting edge until done
//  done          out  1   one-cycle pulse; results valid from this cycle
//  quotient      out  2N  signed quotient, truncated toward zero
//  remainder     out  N   signed remainder, same sign as dividend (or 0)
//  div_by_zero   out  1   last op had divisor==0
//  overflow      out  1   last op was -2^(2N-1) / -1
// BEHAVIOUR
//  Reset (RST=0, any time, including mid-operation): state=IDLE, all outputs
//   0, internal regs cleared. The op in flight is abandoned, with no done.
//  FSM states: IDLE, CALC, FIX.
//   IDLE: start=1 and divisor!=0 -> latch |dividend|, |divisor| (unsigned 2N
//    and N bits), sign_q = sign(dvd)^sign(dvs), sign_r = sign(dvd);
//    cnt=2N; partial rem=0; busy=1; -> CALC.
//   IDLE: start=1 and divisor==0 -> stay IDLE; quotient=0, remainder=0,
//    div_by_zero=1, overflow=0, done=1 next cycle (latency 1).
//   CALC: each edge shift {rem,q} left 1; if rem>=|dvs| then rem-=|dvs|, q[0]=1.
//    Decrement cnt; after 2N iterations -> FIX. rem is N+1 bits internally.
//   FIX: quotient = sign_q ? -q : q; remainder = sign_r ? -rem : rem;
//    overflow = (dividend==-2^(2N-1) && divisor==-1); div_by_zero=0; done=1;
//    busy=0; -> IDLE.
//  Latency: start edge t0 -> done high in the cycle after edge t0+2N+1
//   (2N+1 cycles; 9 for N=4). Throughput: one op per 2N+1 cycles.
//  |-2^(2N-1)| is held exactly in 2N unsigned bits; on overflow the quotient
//   wraps to -2^(2N-1) (8'h80) and remainder=0.
//  start while busy=1 is ignored; input changes after acceptance are ignored.
//  start in the done cycle is accepted (state is already IDLE).
//  quotient/remainder/flags hold their values until the next op completes.
//   They are not cleared by start.
//  done is never high for more than one consecutive cycle unless back-to-back
//   div-by-zero requests are made.
// TESTING
//  100/7 (8'h64,4'h7) -> q=8'h0E, r=4'h2, done exactly 9 cycles after start.
//  Sign matrix: -100/7 -> q=8'hF2,r=4'hE; 100/-7 -> q=8'hF2,r=4'h2;
//   -100/-7 -> q=8'h0E,r=4'hE.
//  Round-trip: 35/-7 -> q=8'hFB(-5),r=0; -128/-8 -> q=8'h10,r=0.
//  -128/-1 -> q=8'h80, r=0, overflow=1; then 6/3 -> q=2, overflow=0.
//  50/0 -> done 1 cycle after start, div_by_zero=1, q=0, r=0, busy stays 0.
//  start pulsed while busy is ignored. RST=0 at iteration 3 -> busy/done/
//   outputs 0 immediately, no done. Next 7/2 -> q=3, r=1.

Source files
------------

// File: rtl/booth2_signed_divider_if.sv
// Request/response bundle for the sequential signed divider.
// Handshake: start is taken on a rising edge only while busy=0; done is a one-cycle pulse and results stay valid until the next completion.
interface booth2_signed_divider_if #(
    parameter int N = 4
);
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/booth2_signed_divider.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per clock,
// then a sign fix. 2N-bit dividend / N-bit divisor -> 2N-bit quotient, N-bit remainder.
module booth2_signed_divider #(
    parameter int N = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    booth2_signed_divider_if.slave        bus,
    output logic [1:0]                    dbg_state
);
    localparam int W  = 2 * N;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    mag_q;
    logic [N-1:0]    dvs_mag;
    logic [N:0]      rem;
    logic            sign_q, sign_r, ovf_pend;

    logic [W-1:0]    quotient_r;
    logic [N-1:0]    remainder_r;
    logic            dbz_r, ovf_r, done_r;

    logic            zero_dvs;
    logic [W-1:0]    dvd_abs;
    logic [N-1:0]    dvs_abs;
    logic [N:0]      rem_sh, rem_diff;
    logic            fits;

    assign zero_dvs = (bus.divisor == '0);
    // |-2^(W-1)| lands exactly on 2^(W-1), which is representable unsigned.
    assign dvd_abs  = bus.dividend[W-1] ? -bus.dividend : bus.dividend;
    assign dvs_abs  = bus.divisor[N-1]  ? -bus.divisor  : bus.divisor;

    assign rem_sh   = {rem[N-1:0], mag_q[W-1]};
    assign rem_diff = rem_sh - {1'b0, dvs_mag};
    assign fits     = (rem_sh >= {1'b0, dvs_mag});

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start && !zero_dvs) state_n = CALC;
            CALC:    if (cnt == CW'(1))          state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt         <= '0;
            mag_q       <= '0;
            dvs_mag     <= '0;
            rem         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            ovf_pend    <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    if (zero_dvs) begin
                        quotient_r  <= '0;
                        remainder_r <= '0;
                        dbz_r       <= 1'b1;
                        ovf_r       <= 1'b0;
                        done_r      <= 1'b1;
                    end else begin
                        mag_q    <= dvd_abs;
                        dvs_mag  <= dvs_abs;
                        sign_q   <= bus.dividend[W-1] ^ bus.divisor[N-1];
                        sign_r   <= bus.dividend[W-1];
                        ovf_pend <= (bus.dividend == {1'b1, {(W-1){1'b0}}}) && (bus.divisor == '1);
                        cnt      <= CW'(W);
                        rem      <= '0;
                    end
                end
                CALC: begin
                    // mag_q doubles as the dividend shifter and the quotient collector.
                    rem   <= fits ? rem_diff : rem_sh;
                    mag_q <= {mag_q[W-2:0], fits};
                    cnt   <= cnt - CW'(1);
                end
                FIX: begin
                    quotient_r  <= sign_q ? -mag_q : mag_q;
                    remainder_r <= sign_r ? -rem[N-1:0] : rem[N-1:0];
                    ovf_r       <= ovf_pend;
                    dbz_r       <= 1'b0;
                    done_r      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.overflow    = ovf_r;
    assign dbg_state       = state;
endmodule

// File: tb/tb_booth2_signed_divider.sv
// Bench for booth2_signed_divider (N=4): directed sign/boundary cases plus random ops,
// checked against an integer-arithmetic reference model through an expected queue.
module tb_booth2_signed_divider;
    localparam int N = 4;
    localparam int W = 14;  // {quotient[7:0], remainder[3:0], div_by_zero, overflow}

    logic       CLK;
    logic       RST;
    logic [1:0] dbg_state;
    int         cyc;
    int         checks;
    int         errors;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           acc_q[$];
    logic [W-1:0] last_out;

    booth2_signed_divider_if #(.N(N)) bus ();

    booth2_signed_divider #(.N(N)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [W-1:0] model(input logic [7:0] a, input logic [3:0] b);
        int sa, sb, q, r;
        sa = $signed(a);
        sb = $signed(b);
        if (sb == 0) return {8'h00, 4'h0, 1'b1, 1'b0};
        if (sa == -128 && sb == -1) return {8'h80, 4'h0, 1'b0, 1'b1};
        q = sa / sb;
        r = sa % sb;
        return {q[7:0], r[3:0], 2'b00};
    endfunction

    function automatic logic [W-1:0] actual();
        return {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow};
    endfunction

    // driver: called at a falling edge; returns at the falling edge after acceptance
    task automatic issue(input logic [7:0] a, input logic [3:0] b);
        int guard;
        guard = 0;
        while (bus.busy && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL issue_wait: busy still %b after %0d cycles, required 0", bus.busy, guard);
        end
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        exp_q.push_back(model(a, b));
        // done offset measured from the cycle following the accepting edge
        lat_q.push_back((b == 4'h0) ? 0 : 2 * N + 1);
        acc_q.push_back(cyc + 1);
        @(negedge CLK);
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom_range(0, 255));
        bus.divisor  = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
            lat_q.delete();
            acc_q.delete();
        end
        @(negedge CLK);
    endtask

    // scoreboard monitor
    initial begin
        logic [W-1:0] e;
        int lat, acc;
        last_out = '0;
        forever begin
            @(negedge CLK);
            #2;
            if (!RST) begin
                last_out = '0;
            end else if (bus.done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d with no request outstanding", cyc);
                end else begin
                    e   = exp_q.pop_front();
                    lat = lat_q.pop_front();
                    acc = acc_q.pop_front();
                    if (actual() !== e) begin
                        errors++;
                        $display("FAIL result: got q=%h r=%h dbz=%b ovf=%b, required q=%h r=%h dbz=%b ovf=%b",
                                 bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow,
                                 e[13:6], e[5:2], e[1], e[0]);
                    end
                    checks++;
                    if (cyc - acc != lat) begin
                        errors++;
                        $display("FAIL latency: got %0d, required %0d", cyc - acc, lat);
                    end
                    checks++;
                    if (bus.busy !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_at_done: got %b, required 0", bus.busy);
                    end
                end
                last_out = actual();
            end else begin
                checks++;
                if (actual() !== last_out) begin
                    errors++;
                    $display("FAIL hold: got %h, required %h", actual(), last_out);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $finish;
    end

    // stimulus
    initial begin
        logic [7:0] a;
        logic [3:0] b;
        checks       = 0;
        errors       = 0;
        RST          = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({bus.busy, bus.done, actual()} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b out=%h, required all 0", bus.busy, bus.done, actual());
        end
        RST = 1'b1;
        @(negedge CLK);

        issue(8'h64, 4'h7);
        issue(8'h9C, 4'h7);
        issue(8'h64, 4'h9);
        issue(8'h9C, 4'h9);
        issue(8'h23, 4'h9);
        issue(8'h80, 4'h8);
        issue(8'h80, 4'hF);
        issue(8'h06, 4'h3);
        issue(8'h32, 4'h0);
        issue(8'h32, 4'h0);
        issue(8'h11, 4'h0);
        issue(8'h07, 4'h2);
        wait_drain();

        // start pulses while busy must be ignored
        issue(8'h64, 4'h7);
        for (int i = 0; i < 3; i++) begin
            bus.start    = 1'b1;
            bus.dividend = 8'h01;
            bus.divisor  = 4'h1;
            #1;
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_during_calc: got %b, required 1", bus.busy);
            end
            @(negedge CLK);
        end
        bus.start = 1'b0;
        wait_drain();

        // reset in the middle of an operation abandons it without done
        issue(8'h9C, 4'h9);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        exp_q.pop_back();
        lat_q.pop_back();
        acc_q.pop_back();
        #1;
        checks++;
        if ({bus.busy, bus.done, actual()} !== '0) begin
            errors++;
            $display("FAIL mid_op_reset: got busy=%b done=%b out=%h, required all 0", bus.busy, bus.done, actual());
        end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (12) @(negedge CLK);
        issue(8'h07, 4'h2);
        wait_drain();

        // random operations, some issued back-to-back in the done cycle
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 4'($urandom_range(0, 15));
            if (i % 15 == 7) begin
                a = 8'h80;
                b = 4'hF;
            end
            issue(a, b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(negedge CLK);
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
